mac_seq_ctrl: RTL

Sequencer for a single signed 8-bit multiply-accumulate datapath in the CNN accelerator. It computes one dot product of up to 2^LEN_W-1 terms: it issues paired activation/weight reads from on-chip buffers, accumulates one product per cycle into a 32-bit register preloaded with a bias, applies optional ReLU, and presents the result on a valid/ready output. It sits between the layer scheduler, which issues `start`, and the output writeback stage.

---
 rtl/mac_ctrl_pkg.sv | 22 ++
 rtl/mac.sv | 18 +
 rtl/mac_seq_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC sequencer and its datapath.
package mac_ctrl_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Negative results clamp to zero when ReLU is enabled; applied after wrap.
    function automatic logic signed [ACC_W-1:0] relu_clamp(
        input logic signed [ACC_W-1:0] v,
        input logic                    en
    );
        return (en && v[ACC_W-1]) ? '0 : v;
    endfunction

endpackage

// File: rtl/mac.sv
// Combinational signed 8x8 multiply plus 32-bit accumulate (wraps modulo 2^32).
module mac
    import mac_ctrl_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [ACC_W-1:0]  acc_in,
    output logic signed [ACC_W-1:0]  sum
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = a * w;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign sum      = acc_in + prod_ext;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: issues paired buffer reads, accumulates one product per
// cycle onto a bias, optionally applies ReLU and holds the result on valid/ready.
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic [ADDR_W-1:0]        base_a,
    input  logic [ADDR_W-1:0]        base_w,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic                     relu_en,
    output logic                     busy,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr_a,
    output logic [ADDR_W-1:0]        rd_addr_w,
    input  logic signed [DATA_W-1:0] rd_data_a,
    input  logic signed [DATA_W-1:0] rd_data_w,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data
);

    state_e                  state;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        cnt_q;
    logic                    relu_q;
    logic                    pend_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] mac_sum;

    mac u_mac (
        .a      (rd_data_a),
        .w      (rd_data_w),
        .acc_in (acc_q),
        .sum    (mac_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            relu_q    <= 1'b0;
            pend_q    <= 1'b0;
            acc_q     <= '0;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_w <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            // Buffer data arrives one cycle after the strobe.
            pend_q <= rd_en;
            if (pend_q) begin
                acc_q <= mac_sum;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= len;
                        relu_q    <= relu_en;
                        acc_q     <= bias;
                        busy      <= 1'b1;
                        rd_addr_a <= base_a;
                        rd_addr_w <= base_w;
                        if (len == '0) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                            res_data  <= relu_clamp(bias, relu_en);
                        end else begin
                            state <= RUN;
                            rd_en <= 1'b1;
                            cnt_q <= LEN_W'(1'b1);
                        end
                    end
                end
                RUN: begin
                    // cnt_q counts reads issued including the one on the bus now.
                    if (cnt_q == len_q) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_addr_a <= rd_addr_a + ADDR_W'(1'b1);
                        rd_addr_w <= rd_addr_w + ADDR_W'(1'b1);
                        cnt_q     <= cnt_q + LEN_W'(1'b1);
                    end
                end
                DRAIN: begin
                    // Final product lands this cycle, so take the datapath sum directly.
                    state     <= DONE;
                    res_valid <= 1'b1;
                    res_data  <= relu_clamp(mac_sum, relu_q);
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
